// File: rtl/gray_sum_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : gray_sum_decoder
//  Purpose  : Receive side of the gray-coded sum interface. Accepts
//             (WIDTH+1)-bit gray sums over valid/ready, decodes them to
//             binary and presents a WIDTH-bit result plus a carry flag
//             through a two-stage registered pipeline with full
//             backpressure. Keeps a saturating count of consumed carries.
//
//  Parameters:
//    WIDTH  - operand width (gray input is WIDTH+1 bits)
//    CNT_W  - width of the carry-event counter
//
//  Ports:
//    clk        in   clock, rising edge
//    rst_n      in   asynchronous active-low reset
//    in_valid   in   in_gray holds a valid sum
//    in_ready   out  sum is accepted this cycle
//    in_gray    in   gray-coded sum [WIDTH:0]
//    out_valid  out  out_bin / out_carry valid
//    out_ready  in   consumer accepts output this cycle
//    out_bin    out  low WIDTH bits of decoded sum
//    out_carry  out  MSB of decoded sum
//    ovf_count  out  consumed outputs with out_carry=1 (saturating)
//    clear      in   synchronous clear of ovf_count (and step_err)
//    step_err   out  sticky multi-bit-step flag (GRAY_SUM_STEP_CHECK_EN only)
//
//  Optional feature macro: GRAY_SUM_STEP_CHECK_EN
//
//  Revision : 1.0 - initial release
// ============================================================================

module gray_sum_decoder #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH:0]   in_gray,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_bin,
    output logic             out_carry,
    output logic [CNT_W-1:0] ovf_count,
    input  logic             clear
`ifdef GRAY_SUM_STEP_CHECK_EN
    ,
    output logic             step_err
`endif
);

    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    // rdy_en keeps in_ready low until the first edge after reset release.
    logic             rdy_en_q,    rdy_en_d;
    logic             s1_valid_q,  s1_valid_d;
    logic [WIDTH:0]   s1_gray_q,   s1_gray_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_bin_q,   out_bin_d;
    logic             out_carry_q, out_carry_d;
    logic [CNT_W-1:0] ovf_count_q, ovf_count_d;

    // ------------------------------------------------------------------
    // Combinational decode between the stages
    // ------------------------------------------------------------------
    // Binary bit i is the XOR of all gray bits from the MSB down to i,
    // which unrolls the b[i] = b[i+1] ^ g[i] recurrence.
    logic [WIDTH:0] dec_bin;

    for (genvar i = 0; i <= WIDTH; i++) begin : g_decode
        assign dec_bin[i] = ^s1_gray_q[WIDTH:i];
    end

    // ------------------------------------------------------------------
    // Handshake and next-state logic
    // ------------------------------------------------------------------
    logic s2_load;
    logic accept;
    logic consume_carry;

    always_comb begin
        s2_load       = s1_valid_q && (!out_valid_q || out_ready);
        in_ready      = rdy_en_q && (!s1_valid_q || s2_load);
        accept        = in_valid && in_ready;
        consume_carry = out_valid_q && out_ready && out_carry_q;

        rdy_en_d    = 1'b1;

        s1_valid_d  = s1_valid_q;
        s1_gray_d   = s1_gray_q;
        if (accept) begin
            s1_valid_d = 1'b1;
            s1_gray_d  = in_gray;
        end else if (s2_load) begin
            s1_valid_d = 1'b0;
        end

        out_valid_d = out_valid_q;
        out_bin_d   = out_bin_q;
        out_carry_d = out_carry_q;
        if (s2_load) begin
            out_valid_d = 1'b1;
            out_bin_d   = dec_bin[WIDTH-1:0];
            out_carry_d = dec_bin[WIDTH];
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

        // clear has priority over a same-cycle increment
        ovf_count_d = ovf_count_q;
        if (clear) begin
            ovf_count_d = '0;
        end else if (consume_carry && (ovf_count_q != c_cnt_max)) begin
            ovf_count_d = ovf_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_en_q    <= 1'b0;
            s1_valid_q  <= 1'b0;
            s1_gray_q   <= '0;
            out_valid_q <= 1'b0;
            out_bin_q   <= '0;
            out_carry_q <= 1'b0;
            ovf_count_q <= '0;
        end else begin
            rdy_en_q    <= rdy_en_d;
            s1_valid_q  <= s1_valid_d;
            s1_gray_q   <= s1_gray_d;
            out_valid_q <= out_valid_d;
            out_bin_q   <= out_bin_d;
            out_carry_q <= out_carry_d;
            ovf_count_q <= ovf_count_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_bin   = out_bin_q;
    assign out_carry = out_carry_q;
    assign ovf_count = ovf_count_q;

`ifdef GRAY_SUM_STEP_CHECK_EN
    // ------------------------------------------------------------------
    // Gray step checker: consecutive accepted codes should differ in at
    // most one bit. Identical codes are tolerated.
    // ------------------------------------------------------------------
    logic [WIDTH:0] hist_gray_q,  hist_gray_d;
    logic           hist_valid_q, hist_valid_d;
    logic           step_err_q,   step_err_d;
    logic [WIDTH:0] step_diff;
    logic           multi_bit;

    always_comb begin
        step_diff = in_gray ^ hist_gray_q;
        // x & (x-1) strips the lowest set bit; anything left means >1 bit.
        multi_bit = |(step_diff & (step_diff - (WIDTH+1)'(1)));

        hist_gray_d  = hist_gray_q;
        hist_valid_d = hist_valid_q;
        step_err_d   = step_err_q;

        if (accept) begin
            hist_gray_d  = in_gray;
            hist_valid_d = 1'b1;
            if (hist_valid_q && multi_bit) begin
                step_err_d = 1'b1;
            end
        end

        if (clear) begin
            hist_valid_d = 1'b0;
            step_err_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_gray_q  <= '0;
            hist_valid_q <= 1'b0;
            step_err_q   <= 1'b0;
        end else begin
            hist_gray_q  <= hist_gray_d;
            hist_valid_q <= hist_valid_d;
            step_err_q   <= step_err_d;
        end
    end

    assign step_err = step_err_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_gray_sum_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gray_sum_decoder
//  Purpose  : Directed self-checking bench for gray_sum_decoder. A second
//             instance with CNT_W=2 shares the stimulus to exercise counter
//             saturation. Inputs are driven and outputs sampled at negedge.
//  Revision : 1.0 - initial release
// ============================================================================

module tb_gray_sum_decoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [4:0] in_gray;
    logic       out_ready;
    logic       clear;

    logic       in_ready,  in_ready2;
    logic       out_valid, out_valid2;
    logic [3:0] out_bin,   out_bin2;
    logic       out_carry, out_carry2;
    logic [7:0] ovf_count;
    logic [1:0] ovf_count2;
`ifdef GRAY_SUM_STEP_CHECK_EN
    logic       step_err, step_err2;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    gray_sum_decoder #(.WIDTH(4), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_gray(in_gray), .out_valid(out_valid), .out_ready(out_ready),
        .out_bin(out_bin), .out_carry(out_carry), .ovf_count(ovf_count),
        .clear(clear)
`ifdef GRAY_SUM_STEP_CHECK_EN
        , .step_err(step_err)
`endif
    );

    gray_sum_decoder #(.WIDTH(4), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
        .in_gray(in_gray), .out_valid(out_valid2), .out_ready(out_ready),
        .out_bin(out_bin2), .out_carry(out_carry2), .ovf_count(ovf_count2),
        .clear(clear)
`ifdef GRAY_SUM_STEP_CHECK_EN
        , .step_err(step_err2)
`endif
    );

    function automatic logic [4:0] to_gray(input int n);
        logic [4:0] b;
        b = n[4:0];
        return b ^ (b >> 1);
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_gray = '0; out_ready = 1'b0; clear = 1'b0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
        checks++; if (out_bin !== 4'h0) begin errors++; $display("FAIL rst_out_bin got %h exp 0", out_bin); end
        checks++; if (out_carry !== 1'b0) begin errors++; $display("FAIL rst_out_carry got %b exp 0", out_carry); end
        checks++; if (ovf_count !== 8'd0) begin errors++; $display("FAIL rst_ovf got %0d exp 0", ovf_count); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %b exp 0", in_ready); end
`ifdef GRAY_SUM_STEP_CHECK_EN
        checks++; if (step_err !== 1'b0) begin errors++; $display("FAIL rst_step_err got %b exp 0", step_err); end
`endif
        rst_n = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rel_in_ready_pre_edge got %b exp 0", in_ready); end
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rel_in_ready_post_edge got %b exp 1", in_ready); end
    endtask

    task automatic test_single();
        in_valid = 1'b1; in_gray = 5'b11011; out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL single_in_ready got %b exp 1", in_ready); end
        @(negedge clk);
        in_valid = 1'b0; in_gray = 5'bxxxxx;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_latency got %b exp 0", out_valid); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_out_valid got %b exp 1", out_valid); end
        checks++; if (out_bin !== 4'h2) begin errors++; $display("FAIL single_out_bin got %h exp 2", out_bin); end
        checks++; if (out_carry !== 1'b1) begin errors++; $display("FAIL single_out_carry got %b exp 1", out_carry); end
        checks++; if (ovf_count !== 8'd0) begin errors++; $display("FAIL single_ovf_pre got %0d exp 0", ovf_count); end
        checks++; if ({out_valid2, out_bin2, out_carry2, in_ready2} !== 7'b1_0010_1_1) begin
            errors++; $display("FAIL single_dut2 got %b exp 1001011", {out_valid2, out_bin2, out_carry2, in_ready2});
        end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_drop got %b exp 0", out_valid); end
        checks++; if (ovf_count !== 8'd1) begin errors++; $display("FAIL single_ovf_post got %0d exp 1", ovf_count); end
        checks++; if (out_bin !== 4'h2) begin errors++; $display("FAIL single_x_isolation got %h exp 2", out_bin); end
        in_gray = '0;
    endtask

    task automatic test_back_to_back();
        logic [4:0] exp_b;
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 34; c++) begin
            if (c >= 2) begin
                exp_b = 5'(c - 2);
                checks++; if (out_valid !== 1'b1 || out_bin !== exp_b[3:0] || out_carry !== exp_b[4]) begin
                    errors++; $display("FAIL b2b_item%0d got v=%b bin=%h c=%b exp v=1 bin=%h c=%b",
                                       c - 2, out_valid, out_bin, out_carry, exp_b[3:0], exp_b[4]);
                end
            end
            if (c < 32) begin
                in_valid = 1'b1; in_gray = to_gray(c);
                #1;
                checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready%0d got %b exp 1", c, in_ready); end
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end
        checks++; if (ovf_count !== 8'd16) begin errors++; $display("FAIL b2b_ovf got %0d exp 16", ovf_count); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got %b exp 0", out_valid); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid = 1'b1; in_gray = 5'b00100;
        @(negedge clk);
        in_gray = to_gray(8);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_second_accept got %b exp 1", in_ready); end
        @(negedge clk);
        in_gray = to_gray(9);
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_full%0d got %b exp 0", k, in_ready); end
            checks++; if (out_valid !== 1'b1 || out_bin !== 4'h7 || out_carry !== 1'b0) begin
                errors++; $display("FAIL bp_hold%0d got v=%b bin=%h c=%b exp v=1 bin=7 c=0", k, out_valid, out_bin, out_carry);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_follows_out_ready got %b exp 1", in_ready); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_bin !== 4'h8) begin errors++; $display("FAIL bp_out_b got v=%b bin=%h exp v=1 bin=8", out_valid, out_bin); end
        in_gray = to_gray(10);
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_bin !== 4'h9) begin errors++; $display("FAIL bp_out_c got v=%b bin=%h exp v=1 bin=9", out_valid, out_bin); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_bin !== 4'hA) begin errors++; $display("FAIL bp_out_d got v=%b bin=%h exp v=1 bin=a", out_valid, out_bin); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got %b exp 0", out_valid); end
    endtask

    task automatic test_saturate();
        int exp2;
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (c >= 3) begin
                exp2 = (c - 2 > 3) ? 3 : c - 2;
                checks++; if (ovf_count2 !== 2'(exp2)) begin errors++; $display("FAIL sat_ovf2_%0d got %0d exp %0d", c - 2, ovf_count2, exp2); end
                checks++; if (ovf_count !== 8'(c - 2)) begin errors++; $display("FAIL sat_ovf8_%0d got %0d exp %0d", c - 2, ovf_count, c - 2); end
            end
            if (c < 5) begin
                in_valid = 1'b1; in_gray = to_gray(16 + c);
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end
        in_valid = 1'b1; in_gray = to_gray(17);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_carry !== 1'b1) begin errors++; $display("FAIL sat_carry_present got v=%b c=%b exp 1 1", out_valid, out_carry); end
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        checks++; if (ovf_count !== 8'd0) begin errors++; $display("FAIL sat_clear_priority got %0d exp 0", ovf_count); end
        checks++; if (ovf_count2 !== 2'd0) begin errors++; $display("FAIL sat_clear_priority2 got %0d exp 0", ovf_count2); end
    endtask

    task automatic test_reset_midflight();
        out_ready = 1'b1;
        in_valid = 1'b1; in_gray = to_gray(20);
        @(negedge clk);
        in_gray = to_gray(21);
        @(negedge clk);
        in_gray = to_gray(22);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        checks++; if (ovf_count !== 8'd1 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
            errors++; $display("FAIL mid_full got ovf=%0d v=%b rdy=%b exp ovf=1 v=1 rdy=0", ovf_count, out_valid, in_ready);
        end
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || ovf_count !== 8'd0 || out_bin !== 4'h0 || in_ready !== 1'b0) begin
            errors++; $display("FAIL mid_async_rst got v=%b ovf=%0d bin=%h rdy=%b exp 0 0 0 0", out_valid, ovf_count, out_bin, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        out_ready = 1'b1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_discard got %b exp 0", out_valid); end
        in_valid = 1'b1; in_gray = to_gray(5);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_ready got %b exp 1", in_ready); end
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_latency got %b exp 0", out_valid); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_bin !== 4'h5 || out_carry !== 1'b0) begin
            errors++; $display("FAIL mid_first_sum got v=%b bin=%h c=%b exp 1 5 0", out_valid, out_bin, out_carry);
        end
        @(negedge clk);
    endtask

`ifdef GRAY_SUM_STEP_CHECK_EN
    task automatic test_step_check();
        out_ready = 1'b1;
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        in_valid = 1'b1; in_gray = 5'b00000;
        @(negedge clk);
        in_gray = 5'b00001;
        @(negedge clk);
        in_gray = 5'b00001;
        @(negedge clk);
        checks++; if (step_err !== 1'b0) begin errors++; $display("FAIL step_single_and_equal got %b exp 0", step_err); end
        in_gray = 5'b00111;
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (step_err !== 1'b1) begin errors++; $display("FAIL step_set got %b exp 1", step_err); end
        checks++; if (step_err2 !== 1'b1) begin errors++; $display("FAIL step_set2 got %b exp 1", step_err2); end
        @(negedge clk);
        @(negedge clk);
        checks++; if (step_err !== 1'b1) begin errors++; $display("FAIL step_sticky got %b exp 1", step_err); end
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        checks++; if (step_err !== 1'b0) begin errors++; $display("FAIL step_clear got %b exp 0", step_err); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_saturate();
        test_reset_midflight();
`ifdef GRAY_SUM_STEP_CHECK_EN
        test_step_check();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
